wb_stream_reader_ctrl: RTL and testbench
========================================

Name: wb_stream_reader_ctrl

Overview:
- Wishbone B4 burst-write master that drains a show-ahead stream FIFO into a circular memory buffer.
- It is the write-to-memory counterpart of the memory-to-FIFO stream writer controller.
- Sits between the stream input FIFO (e.g. sensor pixel path) and the system bus / DRAM port.
- Configured by a CSR block through the enable, start_adr, buf_size and burst_size inputs.

Parameters:
- WB_AW, 32, Wishbone address width.
- WB_DW, 32, Wishbone data width; fixed at 32 (byte stride 4).
- FIFO_AW, 6, FIFO depth is 2**FIFO_AW words; fifo_cnt width is FIFO_AW+1.
- MAX_BURST_LEN, 16, largest legal burst_size; sizes burst_cnt to $clog2(MAX_BURST_LEN)+1 bits.
- TIMEOUT_CYCLES, 256, ack watchdog limit; used only with the optional feature.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_ni  in  1  asynchronous active-low reset.
- wbm_adr_o  out  WB_AW  byte address.
- wbm_dat_o  out  WB_DW  write data, equal to fifo_d.
- wbm_sel_o  out  WB_DW/8  all ones.
- wbm_we_o  out  1  constant 1.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_cti_o  out  3  cycle type.
- wbm_bte_o  out  2  constant 2'b00 (linear).
- wbm_ack_i  in  1  slave acknowledge.
- wbm_err_i  in  1  slave error.
- fifo_d  in  WB_DW  FIFO head word (show-ahead).
- fifo_rd  out  1  pop strobe.
- fifo_cnt  in  FIFO_AW+1  FIFO fill level.
- enable  in  1  single-cycle start pulse.
- busy  out  1  buffer fill in progress.
- err  out  1  sticky bus-error/timeout flag, cleared by enable.
- irq  out  1  one-cycle pulse when the buffer wraps.
- tx_cnt  out  WB_AW  word index of the next write.
- start_adr  in  WB_AW  buffer base address, 4-byte aligned.
- buf_size  in  WB_AW  buffer length in bytes; multiple of 4*burst_size.
- burst_size  in  WB_AW  words per burst, 1..MAX_BURST_LEN.

Behaviour:
- Reset (async, wb_rst_ni low): state=S_IDLE; busy, err, irq, tx_cnt, burst_cnt all 0; cyc/stb 0; cti 3'b000.
- Outputs
  - wbm_adr_o = start_adr + tx_cnt*4 (combinational).
  - fifo_rd = wbm_ack_i & active. Each ack pops exactly one word.
- S_IDLE
  - enable sets busy=1, clears err, loads tx_cnt=0.
  - If busy and fifo_cnt >= burst_size, go to S_ACTIVE on the next edge. Earliest bus cycle is 1 cycle after the condition holds.
- S_ACTIVE
  - cyc = stb = 1.
  - cti = 3'b111 when burst_cnt == burst_size-1, else 3'b010.
  - Each ack increments burst_cnt and tx_cnt.
  - On ack of the last word: tx_cnt wraps to 0 if tx_cnt == buf_size/4-1. On that wrap, busy clears and irq pulses 1 cycle. Then return to S_IDLE.
  - cyc drops for at least one cycle between bursts.
- Error: wbm_err_i in S_ACTIVE → S_ERROR.
  - Drop cyc immediately.
  - Set err=1, busy=0.
  - fifo_rd not asserted; tx_cnt unchanged.
- S_ERROR → S_IDLE after one cycle. No new burst starts until the next enable.
- Simultaneous ack and err: err wins and the word is not popped.
- enable while busy: ignored.
- Reset mid-burst: cyc drops asynchronously; partial burst is abandoned.
- burst_cnt clears whenever not active.

Optional Feature:
- Macro: WB_STREAM_READER_TIMEOUT_EN.
- When defined:
  - A counter runs while cyc=1 with no ack and resets on each ack.
  - Reaching TIMEOUT_CYCLES aborts the burst exactly as wbm_err_i does (err=1, busy=0, S_ERROR).
- When undefined: no counter exists and stalls wait forever.

Decomposition:
- Package wb_stream_pkg:
  - state localparams S_IDLE/S_ACTIVE/S_ERROR.
  - CTI constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111.
  - Shared with the writer controller.
- One natural sub-module, wb_stream_addr_gen: tx_cnt register, wrap compare, adr computation. Reusable by both controllers.

Test Plan:
- Basic fill: start_adr=0x1000, buf_size=64, burst_size=4, FIFO preloaded with 16 words, zero-wait slave → 4 bursts; adr 0x1000..0x103C; cti 010,010,010,111 per burst; irq once; busy=0; memory equals FIFO order.
- FIFO threshold: fifo_cnt=3, burst_size=4 → no cyc. Raise fifo_cnt to 4 → cyc asserts within 2 cycles.
- Wait states: slave inserts 3 wait cycles per ack → fifo_rd exactly 4 pulses per burst, data stable while stb held.
- Bus error: wbm_err_i on the 2nd beat → cyc low the next cycle; err=1, busy=0; tx_cnt=1; fifo popped once; no restart until enable.
- Async reset mid-burst: wb_rst_ni low on beat 2 → cyc, busy, tx_cnt go 0 without a clock edge.
- Timeout (with WB_STREAM_READER_TIMEOUT_EN, TIMEOUT_CYCLES=8): slave never acks → cyc drops after 8 cycles; err=1. Without the macro, cyc stays high for 100 cycles.

Source files
------------

// File: rtl/wb_stream_pkg.sv
// wb_stream_pkg: state and cycle-type definitions shared by the stream reader/writer controllers.
package wb_stream_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_ERROR} state_t;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
endpackage

// File: rtl/wb_stream_reader_ctrl_if.sv
// wb_stream_reader_ctrl_if: Wishbone B4 master/slave bus bundle.
interface wb_stream_reader_ctrl_if #(parameter int AW = 32, parameter int DW = 32);
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat;
    logic [DW/8-1:0] sel;
    logic            we;
    logic            cyc;
    logic            stb;
    logic [2:0]      cti;
    logic [1:0]      bte;
    logic            ack;
    logic            err;
    modport master(output adr, dat, sel, we, cyc, stb, cti, bte, input ack, err);
    modport slave(input adr, dat, sel, we, cyc, stb, cti, bte, output ack, err);
endinterface

// File: rtl/wb_stream_addr_gen.sv
// wb_stream_addr_gen: circular word index into a buffer and the resulting byte address.
module wb_stream_addr_gen #(
    parameter int WB_AW = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [WB_AW-1:0] i_start_adr,
    input  logic [WB_AW-1:0] i_buf_size,
    output logic [WB_AW-1:0] o_adr,
    output logic [WB_AW-1:0] o_tx_cnt,
    output logic             o_last
);
    logic [WB_AW-1:0] r_tx_cnt;
    assign o_last   = r_tx_cnt == (i_buf_size >> 2) - WB_AW'(1);
    assign o_adr    = i_start_adr + (r_tx_cnt << 2);
    assign o_tx_cnt = r_tx_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_tx_cnt <= '0;
        else if (i_clr) r_tx_cnt <= '0;
        else if (i_inc) r_tx_cnt <= o_last ? '0 : r_tx_cnt + WB_AW'(1);
    end
endmodule

// File: rtl/wb_stream_reader_ctrl.sv
// wb_stream_reader_ctrl: Wishbone burst-write master draining a show-ahead FIFO into a circular buffer.
// Optional ack watchdog is compiled in with WB_STREAM_READER_TIMEOUT_EN.
module wb_stream_reader_ctrl
    import wb_stream_pkg::*;
#(
    parameter int WB_AW          = 32,
    parameter int WB_DW          = 32,
    parameter int FIFO_AW        = 6,
    parameter int MAX_BURST_LEN  = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    wb_stream_reader_ctrl_if.master wbm,
    input  logic [WB_DW-1:0]       fifo_d,
    output logic                   fifo_rd,
    input  logic [FIFO_AW:0]       fifo_cnt,
    input  logic                   enable,
    output logic                   busy,
    output logic                   err,
    output logic                   irq,
    output logic [WB_AW-1:0]       tx_cnt,
    input  logic [WB_AW-1:0]       start_adr,
    input  logic [WB_AW-1:0]       buf_size,
    input  logic [WB_AW-1:0]       burst_size
);
    localparam int BW = $clog2(MAX_BURST_LEN) + 1;
    state_t        r_state;
    logic          r_busy, r_err, r_irq;
    logic [BW-1:0] r_burst_cnt;
    logic          w_active, w_start, w_ready, w_eob, w_pop, w_abort, w_last, w_timeout;
    assign w_active = r_state == S_ACTIVE;
    assign w_start  = enable & ~r_busy;
    assign w_ready  = WB_AW'(fifo_cnt) >= burst_size;
    assign w_eob    = WB_AW'(r_burst_cnt) == burst_size - WB_AW'(1);
    assign w_abort  = w_active & (wbm.err | w_timeout);
    assign w_pop    = w_active & wbm.ack & ~wbm.err;
`ifdef WB_STREAM_READER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_to_cnt;
    assign w_timeout = w_active & ~wbm.ack & (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) r_to_cnt <= '0;
        else r_to_cnt <= (w_active & ~wbm.ack & ~w_timeout) ? r_to_cnt + TW'(1) : '0;
    end
`else
    assign w_timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif
    wb_stream_addr_gen #(.WB_AW(WB_AW)) u_addr_gen (
        .i_clk       (wb_clk_i),
        .i_rst_n     (wb_rst_ni),
        .i_clr       (w_start),
        .i_inc       (w_pop),
        .i_start_adr (start_adr),
        .i_buf_size  (buf_size),
        .o_adr       (wbm.adr),
        .o_tx_cnt    (tx_cnt),
        .o_last      (w_last)
    );
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_irq       <= 1'b0;
            r_burst_cnt <= '0;
        end else begin
            r_irq       <= w_pop & w_eob & w_last;
            r_burst_cnt <= w_active ? r_burst_cnt + BW'(w_pop) : '0;
            if (w_start) begin
                r_busy <= 1'b1;
                r_err  <= 1'b0;
            end
            case (r_state)
                S_IDLE: if (r_busy && w_ready) r_state <= S_ACTIVE;
                S_ACTIVE: begin
                    if (w_abort) begin
                        r_state <= S_ERROR;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_pop && w_eob) begin
                        r_state <= S_IDLE;
                        if (w_last) r_busy <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign wbm.cyc = w_active;
    assign wbm.stb = w_active;
    assign wbm.cti = w_active ? (w_eob ? CTI_EOB : CTI_INCR) : CTI_CLASSIC;
    assign wbm.we  = 1'b1;
    assign wbm.sel = '1;
    assign wbm.bte = 2'b00;
    assign wbm.dat = fifo_d;
    assign fifo_rd = w_pop;
    assign busy    = r_busy;
    assign err     = r_err;
    assign irq     = r_irq;
endmodule

// File: tb/tb_wb_stream_reader_ctrl.sv
// tb_wb_stream_reader_ctrl: directed bench with a Wishbone slave model and a show-ahead FIFO model.
module tb_wb_stream_reader_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] start_adr = 32'h1000;
    logic [31:0] buf_size = 32'd64;
    logic [31:0] burst_size = 32'd4;
    logic        fifo_rd, busy, err, irq;
    logic [31:0] tx_cnt;
    logic [31:0] fifo_mem [0:63];
    logic [31:0] fifo_d;
    logic [6:0]  fifo_cnt;
    int rd_ptr = 0, level = 0, applied = 0;
    int n_tests = 0, n_fail = 0;
    int ws = 0, err_beat = -1, no_ack = 0, wcnt = 0;
    int n_beats = 0, pop_cnt = 0, cyc_hi = 0, cyc_rise = 0, irq_cnt = 0, stable_bad = 0;
    logic [31:0] log_adr [0:63];
    logic [31:0] log_dat [0:63];
    logic [2:0]  log_cti [0:63];
    logic        prev_cyc = 1'b0, prev_cs = 1'b0, prev_rd = 1'b0;
    logic [31:0] prev_dat = '0, prev_adr = '0;

    wb_stream_reader_ctrl_if #(.AW(32), .DW(32)) bus ();

    wb_stream_reader_ctrl #(
        .WB_AW(32), .WB_DW(32), .FIFO_AW(6), .MAX_BURST_LEN(16), .TIMEOUT_CYCLES(8)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbm        (bus),
        .fifo_d     (fifo_d),
        .fifo_rd    (fifo_rd),
        .fifo_cnt   (fifo_cnt),
        .enable     (enable),
        .busy       (busy),
        .err        (err),
        .irq        (irq),
        .tx_cnt     (tx_cnt),
        .start_adr  (start_adr),
        .buf_size   (buf_size),
        .burst_size (burst_size)
    );

    assign fifo_d   = fifo_mem[rd_ptr[5:0]];
    assign fifo_cnt = 7'(level);

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Slave: pops seen at the previous negedge take effect after the edge, then ack/err is decided.
    initial begin
        bus.ack = 1'b0;
        bus.err = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            while (applied < pop_cnt) begin
                rd_ptr++;
                level--;
                applied++;
            end
            #1;
            if (!(bus.cyc && bus.stb)) begin
                bus.ack = 1'b0;
                bus.err = 1'b0;
                wcnt = 0;
            end else if (no_ack != 0 || bus.err) begin
                bus.ack = 1'b0;
                bus.err = 1'b0;
            end else if (wcnt == ws) begin
                wcnt = 0;
                if (n_beats == err_beat) begin
                    bus.ack = 1'b1;
                    bus.err = 1'b1;
                    err_beat = -1;
                end else begin
                    bus.ack = 1'b1;
                    log_adr[n_beats] = bus.adr;
                    log_dat[n_beats] = bus.dat;
                    log_cti[n_beats] = bus.cti;
                    n_beats++;
                end
            end else begin
                bus.ack = 1'b0;
                wcnt++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (fifo_rd) pop_cnt++;
            if (irq) irq_cnt++;
            if (bus.cyc) cyc_hi++;
            if (bus.cyc && !prev_cyc) cyc_rise++;
            if (bus.cyc && bus.stb && prev_cs && !prev_rd && (bus.dat !== prev_dat || bus.adr !== prev_adr))
                stable_bad++;
            prev_cyc = bus.cyc;
            prev_cs  = bus.cyc && bus.stb;
            prev_rd  = fifo_rd;
            prev_dat = bus.dat;
            prev_adr = bus.adr;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        enable = 1'b0;
        ws = 0;
        err_beat = -1;
        no_ack = 0;
        @(negedge clk);
        @(negedge clk);
        n_beats = 0; pop_cnt = 0; applied = 0; cyc_hi = 0; cyc_rise = 0; irq_cnt = 0; stable_bad = 0;
        rst_n = 1'b1;
    endtask

    task automatic load_fifo(input int n);
        for (int i = 0; i < 64; i++) fifo_mem[i] = 32'hC0DE_0000 + 32'(i);
        rd_ptr = 0;
        level = n;
    endtask

    task automatic pulse_enable();
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        int k;
        k = 0;
        while (busy && k < max_cycles) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, want 0", name, busy, k);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if ({bus.cyc, bus.stb, busy, err, irq, fifo_rd} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: cyc,stb,busy,err,irq,rd=%b want 000000", {bus.cyc, bus.stb, busy, err, irq, fifo_rd});
        end
        n_tests++;
        if (tx_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_tx_cnt: got %0d want 0", tx_cnt);
        end
        n_tests++;
        if (bus.cti !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_cti: got %b want 000", bus.cti);
        end
        n_tests++;
        if ({bus.we, bus.sel, bus.bte} !== 7'b1_1111_00) begin
            n_fail++;
            $display("FAIL reset_consts: we,sel,bte=%b want 1111100", {bus.we, bus.sel, bus.bte});
        end
        n_tests++;
        if (bus.adr !== 32'h1000) begin
            n_fail++;
            $display("FAIL reset_adr: got %h want 00001000", bus.adr);
        end
    endtask

    task automatic test_basic_fill();
        do_reset();
        start_adr = 32'h1000; buf_size = 32'd64; burst_size = 32'd4;
        load_fifo(16);
        pulse_enable();
        wait_idle(300, "basic");
        repeat (2) @(negedge clk);
        n_tests++;
        if (n_beats !== 16 || pop_cnt !== 16) begin
            n_fail++;
            $display("FAIL basic_beats: beats=%0d pops=%0d want 16 16", n_beats, pop_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (log_adr[i] !== 32'h1000 + 32'(4 * i) || log_dat[i] !== 32'hC0DE_0000 + 32'(i)
                || log_cti[i] !== ((i % 4 == 3) ? 3'b111 : 3'b010)) begin
                n_fail++;
                $display("FAIL basic_beat%0d: adr=%h dat=%h cti=%b want %h %h %b", i, log_adr[i], log_dat[i], log_cti[i],
                         32'h1000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), (i % 4 == 3) ? 3'b111 : 3'b010);
            end
        end
        n_tests++;
        if (cyc_rise !== 4) begin
            n_fail++;
            $display("FAIL basic_bursts: got %0d want 4", cyc_rise);
        end
        n_tests++;
        if (irq_cnt !== 1) begin
            n_fail++;
            $display("FAIL basic_irq: got %0d pulses want 1", irq_cnt);
        end
        n_tests++;
        if (tx_cnt !== 32'd0 || err !== 1'b0 || bus.cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_final: tx_cnt=%0d err=%b cyc=%b want 0 0 0", tx_cnt, err, bus.cyc);
        end
    endtask

    task automatic test_threshold();
        bit seen;
        do_reset();
        start_adr = 32'h2000; buf_size = 32'd64; burst_size = 32'd4;
        load_fifo(3);
        pulse_enable();
        repeat (10) @(negedge clk);
        n_tests++;
        if (cyc_rise !== 0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL thresh_hold: cyc_rises=%0d busy=%b want 0 1", cyc_rise, busy);
        end
        level = 4;
        seen = 1'b0;
        for (int k = 0; k < 2 && !seen; k++) begin
            @(negedge clk);
            seen = bus.cyc;
        end
        n_tests++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL thresh_start: cyc=%b within 2 cycles, want 1", seen);
        end
        repeat (8) @(negedge clk);
        n_tests++;
        if (tx_cnt !== 32'd4 || busy !== 1'b1 || bus.cyc !== 1'b0 || pop_cnt !== 4) begin
            n_fail++;
            $display("FAIL thresh_after: tx_cnt=%0d busy=%b cyc=%b pops=%0d want 4 1 0 4", tx_cnt, busy, bus.cyc, pop_cnt);
        end
        n_tests++;
        if (log_adr[3] !== 32'h200C || log_cti[3] !== 3'b111) begin
            n_fail++;
            $display("FAIL thresh_last: adr=%h cti=%b want 0000200c 111", log_adr[3], log_cti[3]);
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        start_adr = 32'h4000; buf_size = 32'd32; burst_size = 32'd4;
        ws = 3;
        load_fifo(8);
        pulse_enable();
        wait_idle(300, "wait");
        repeat (2) @(negedge clk);
        n_tests++;
        if (pop_cnt !== 8 || n_beats !== 8 || cyc_rise !== 2) begin
            n_fail++;
            $display("FAIL wait_counts: pops=%0d beats=%0d bursts=%0d want 8 8 2", pop_cnt, n_beats, cyc_rise);
        end
        n_tests++;
        if (stable_bad !== 0) begin
            n_fail++;
            $display("FAIL wait_stable: %0d cycles with changed adr/dat while stalled, want 0", stable_bad);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (log_adr[i] !== 32'h4000 + 32'(4 * i) || log_dat[i] !== 32'hC0DE_0000 + 32'(i)) begin
                n_fail++;
                $display("FAIL wait_beat%0d: adr=%h dat=%h want %h %h", i, log_adr[i], log_dat[i],
                         32'h4000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
            end
        end
        n_tests++;
        if (irq_cnt !== 1 || tx_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL wait_wrap: irq=%0d tx_cnt=%0d want 1 0", irq_cnt, tx_cnt);
        end
    endtask

    task automatic test_bus_error();
        int k;
        do_reset();
        start_adr = 32'h1000; buf_size = 32'd64; burst_size = 32'd4;
        load_fifo(8);
        err_beat = 1;
        pulse_enable();
        k = 0;
        while (bus.err !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (bus.err !== 1'b1 || bus.cyc !== 1'b1 || fifo_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL err_beat: slave_err=%b cyc=%b fifo_rd=%b want 1 1 0", bus.err, bus.cyc, fifo_rd);
        end
        @(negedge clk);
        n_tests++;
        if (bus.cyc !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL err_abort: cyc=%b err=%b busy=%b want 0 1 0", bus.cyc, err, busy);
        end
        n_tests++;
        if (tx_cnt !== 32'd1 || pop_cnt !== 1) begin
            n_fail++;
            $display("FAIL err_count: tx_cnt=%0d pops=%0d want 1 1", tx_cnt, pop_cnt);
        end
        repeat (10) @(negedge clk);
        n_tests++;
        if (cyc_rise !== 1 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_no_restart: bursts=%0d err=%b want 1 1", cyc_rise, err);
        end
        pulse_enable();
        n_tests++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL err_clear: err=%b busy=%b want 0 1", err, busy);
        end
    endtask

    task automatic test_async_reset();
        int k;
        do_reset();
        start_adr = 32'h1000; buf_size = 32'd64; burst_size = 32'd4;
        load_fifo(8);
        pulse_enable();
        k = 0;
        while (n_beats < 2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (bus.cyc !== 1'b1 || tx_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL arst_pre: cyc=%b tx_cnt=%0d want 1 1", bus.cyc, tx_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.cyc !== 1'b0 || busy !== 1'b0 || tx_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL arst_async: cyc=%b busy=%b tx_cnt=%0d want 0 0 0", bus.cyc, busy, tx_cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        start_adr = 32'h1000; buf_size = 32'd64; burst_size = 32'd4;
        load_fifo(8);
        no_ack = 1;
        pulse_enable();
`ifdef WB_STREAM_READER_TIMEOUT_EN
        repeat (30) @(negedge clk);
        n_tests++;
        if (cyc_hi !== 8) begin
            n_fail++;
            $display("FAIL timeout_len: cyc high %0d cycles want 8", cyc_hi);
        end
        n_tests++;
        if (err !== 1'b1 || busy !== 1'b0 || bus.cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_abort: err=%b busy=%b cyc=%b want 1 0 0", err, busy, bus.cyc);
        end
`else
        repeat (110) @(negedge clk);
        n_tests++;
        if (cyc_hi < 100 || bus.cyc !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold: cyc high %0d cycles cyc=%b want >=100 1", cyc_hi, bus.cyc);
        end
        n_tests++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_flags: err=%b busy=%b want 0 1", err, busy);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_threshold();
        test_wait_states();
        test_bus_error();
        test_async_reset();
        test_timeout();
        do_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
